// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational off fetch_pc; updates from execute commit on the rising clock.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 30 - IDX_W,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      fetch_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_next_pc,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [CNT_W-1:0] r_misCnt;

  logic [IDX_W-1:0] w_fetchIdx;
  logic [TAG_W-1:0] w_fetchTag;
  logic             w_fetchHit;
  logic [IDX_W-1:0] w_updIdx;
  logic [TAG_W-1:0] w_updTag;
  logic             w_updHit;
  logic             w_unusedPcBits;

  // PCs are word aligned, so the two low bits carry no information.
  assign w_unusedPcBits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign w_fetchIdx = fetch_pc[IDX_W+1:2];
  assign w_fetchTag = fetch_pc[31:IDX_W+2];
  assign w_fetchHit = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);

  assign w_updIdx = upd_pc[IDX_W+1:2];
  assign w_updTag = upd_pc[31:IDX_W+2];
  assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

  assign pred_taken     = w_fetchHit & r_ctr[w_fetchIdx][1];
  assign pred_next_pc   = pred_taken ? r_target[w_fetchIdx] : fetch_pc + 32'd4;
  assign mispredict_cnt = r_misCnt;

  // Lookup reads the pre-update array; a same-index write shows up next cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
      end
    end else if (upd_valid) begin
      if (w_updHit) begin
        if (upd_taken) begin
          if (r_ctr[w_updIdx] != 2'b11) r_ctr[w_updIdx] <= r_ctr[w_updIdx] + 2'd1;
          r_target[w_updIdx] <= upd_target;
        end else if (r_ctr[w_updIdx] != 2'b00) begin
          r_ctr[w_updIdx] <= r_ctr[w_updIdx] - 2'd1;
        end
      end else if (upd_taken) begin
        r_valid[w_updIdx]  <= 1'b1;
        r_tag[w_updIdx]    <= w_updTag;
        r_target[w_updIdx] <= upd_target;
        r_ctr[w_updIdx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_misCnt <= '0;
    end else if (upd_valid && (upd_pred_taken != upd_taken) && (r_misCnt != '1)) begin
      r_misCnt <= r_misCnt + CNT_W'(1);
    end
  end

endmodule
